// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon permutation datapath.
package ascon_pkg;
  localparam int MAX_ROUNDS_C = 12;
  localparam int NUM_SBOXES_C = 64;

  // Element [k] holds word xk.
  typedef logic [4:0][63:0] t_state_array;

  typedef enum logic [1:0] {IDLE, RUN, DONE} t_perm_fsm;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction
endpackage

// File: rtl/ascon_sbox.sv
// Single 5-bit Ascon S-box column. Bit 4 of the column is x0 and bit 0 is x4.
module ascon_sbox (
  input  logic [4:0] i_col,
  output logic [4:0] o_col
);
  logic w_a0, w_a1, w_a2, w_a3, w_a4;
  logic w_b0, w_b1, w_b2, w_b3, w_b4;

  assign w_a0 = i_col[4] ^ i_col[0];
  assign w_a1 = i_col[3];
  assign w_a2 = i_col[2] ^ i_col[3];
  assign w_a3 = i_col[1];
  assign w_a4 = i_col[0] ^ i_col[1];

  // Chi-like nonlinear core.
  assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
  assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
  assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
  assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
  assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

  assign o_col = {w_b0 ^ w_b4, w_b1 ^ w_b0, ~w_b2, w_b3 ^ w_b2, w_b4};
endmodule

// File: rtl/ascon_sub_layer.sv
// Substitution layer: one S-box per bit column across the five state words.
module ascon_sub_layer
  import ascon_pkg::*;
#(
  parameter int NUM_SBOXES = NUM_SBOXES_C
) (
  input  t_state_array i_state,
  output t_state_array o_state
);
  for (genvar i = 0; i < NUM_SBOXES; i++) begin : g_col
    logic [4:0] w_out;
    ascon_sbox u_sbox (
      .i_col({i_state[0][i], i_state[1][i], i_state[2][i], i_state[3][i], i_state[4][i]}),
      .o_col(w_out)
    );
    assign o_state[0][i] = w_out[4];
    assign o_state[1][i] = w_out[3];
    assign o_state[2][i] = w_out[2];
    assign o_state[3][i] = w_out[1];
    assign o_state[4][i] = w_out[0];
  end
endmodule

// File: rtl/lin_layer.sv
// Ascon linear diffusion layer: per-word XOR of two right-rotations.
module lin_layer
  import ascon_pkg::*;
(
  input  t_state_array i_state,
  output t_state_array o_state
);
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  assign o_state[0] = i_state[0] ^ rotr(i_state[0], 19) ^ rotr(i_state[0], 28);
  assign o_state[1] = i_state[1] ^ rotr(i_state[1], 61) ^ rotr(i_state[1], 39);
  assign o_state[2] = i_state[2] ^ rotr(i_state[2], 1)  ^ rotr(i_state[2], 6);
  assign o_state[3] = i_state[3] ^ rotr(i_state[3], 10) ^ rotr(i_state[3], 17);
  assign o_state[4] = i_state[4] ^ rotr(i_state[4], 7)  ^ rotr(i_state[4], 41);
endmodule

// File: rtl/perm_sequencer.sv
// Iterative Ascon p^n engine, one round per edge with valid/ready on both sides.
// Optional PERM_SPLIT_ROUND_EN registers after the S-box layer, two edges per round.
module perm_sequencer
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = MAX_ROUNDS_C,
  parameter int NUM_SBOXES = NUM_SBOXES_C
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [3:0]   i_rounds,
  input  t_state_array i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output t_state_array o_state,
  output logic         o_busy
);
  localparam logic [3:0] MAX_R  = 4'(MAX_ROUNDS);
  localparam logic [3:0] LAST_R = 4'(MAX_ROUNDS - 1);

  t_perm_fsm    r_fsm, w_fsm_nxt;
  t_state_array r_state;
  logic [3:0]   r_round;
  logic [3:0]   w_n;
  logic         w_start, w_adv, w_last;
  t_state_array w_ca, w_sub, w_lin_in, w_lin;

  assign w_n     = (i_rounds > MAX_R) ? MAX_R : i_rounds;
  assign w_start = i_valid & o_ready;

  always_comb begin
    w_ca          = r_state;
    w_ca[2][7:0]  = r_state[2][7:0] ^ round_const(r_round);
  end

  ascon_sub_layer #(.NUM_SBOXES(NUM_SBOXES)) u_sub (
    .i_state(w_ca),
    .o_state(w_sub)
  );

  lin_layer u_lin (
    .i_state(w_lin_in),
    .o_state(w_lin)
  );

`ifdef PERM_SPLIT_ROUND_EN
  // r_phase: 0 = SUB edge (fill pipe), 1 = LIN edge (commit round).
  logic         r_phase;
  t_state_array r_pipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= 1'b0;
      r_pipe  <= '0;
    end else if (r_fsm == RUN) begin
      r_phase <= ~r_phase;
      if (!r_phase) r_pipe <= w_sub;
    end
  end

  assign w_lin_in = r_pipe;
  assign w_adv    = r_phase;
`else
  assign w_lin_in = w_sub;
  assign w_adv    = 1'b1;
`endif

  assign w_last = (r_fsm == RUN) && w_adv && (r_round == LAST_R);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      IDLE:    if (w_start) w_fsm_nxt = (w_n == 4'd0) ? DONE : RUN;
      RUN:     if (w_last) w_fsm_nxt = DONE;
      DONE:    if (i_ready) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_fsm == IDLE);
    o_valid = (r_fsm == DONE);
    o_busy  = (r_fsm == RUN);
  end

  // Round index counts up from MAX_ROUNDS-n so the constants match the tail of p^12.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= '0;
      r_round <= '0;
    end else if (w_start) begin
      r_state <= i_state;
      r_round <= MAX_R - w_n;
    end else if (r_fsm == RUN && w_adv) begin
      r_state <= w_lin;
      r_round <= r_round + 4'd1;
    end
  end

  assign o_state = r_state;
endmodule

// File: tb/tb_perm_sequencer.sv
// Directed bench for perm_sequencer; expected states come from a table-driven reference model.
module tb_perm_sequencer;
  import ascon_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [3:0]   i_rounds = 4'd0;
  t_state_array i_state = '0;
  logic         o_ready, o_valid, o_busy;
  t_state_array o_state;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clock = ~clock;

  perm_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_rounds(i_rounds),
    .i_state (i_state),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_state (o_state),
    .o_busy  (o_busy)
  );

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic t_state_array m_round(input t_state_array s, input int r);
    t_state_array t;
    logic [4:0]   c;
    s[2][7:0] = s[2][7:0] ^ {4'(15 - r), 4'(r)};
    for (int i = 0; i < 64; i++) begin
      c = SBOX[{s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}];
      for (int j = 0; j < 5; j++) t[j][i] = c[4-j];
    end
    s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
    s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
    s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
    s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
    s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
    return s;
  endfunction

  function automatic int clampn(input int n);
    return (n > 12) ? 12 : n;
  endfunction

  function automatic t_state_array m_perm(input t_state_array s, input int n);
    for (int r = 12 - clampn(n); r < 12; r++) s = m_round(s, r);
    return s;
  endfunction

  function automatic int exp_lat(input int n);
`ifdef PERM_SPLIT_ROUND_EN
    return 2 * clampn(n) + 1;
`else
    return clampn(n) + 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Handshake at E0, then scramble i_rounds to show it is sampled only once.
  task automatic start(input t_state_array s, input logic [3:0] n);
    i_state  = s;
    i_rounds = n;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    i_rounds = 4'd0;
  endtask

  task automatic wait_valid(input int lat0, output int lat);
    lat = lat0;
    while (!o_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, " accept valid"}, 320'(o_valid), 320'(0));
    chk({tag, " accept ready"}, 320'(o_ready), 320'(1));
  endtask

  task automatic run_chk(input string tag, input t_state_array s, input logic [3:0] n);
    int lat;
    t_state_array exp;
    exp = m_perm(s, int'(n));
    start(s, n);
    wait_valid(1, lat);
    chk({tag, " latency"}, 320'(lat), 320'(exp_lat(int'(n))));
    chk({tag, " state"}, o_state, exp);
    accept(tag);
  endtask

  initial begin
    t_state_array s, init, exp, other;
    logic [63:0]  a, b;
    int           lat;

    // Reset values.
    tick();
    tick();
    chk("rst ready", 320'(o_ready), 320'(1));
    chk("rst valid", 320'(o_valid), 320'(0));
    chk("rst busy",  320'(o_busy),  320'(0));
    chk("rst state", o_state, '0);
    reset = 1'b0;
    tick();

    // i_ready while idle is ignored.
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("idle iready ready", 320'(o_ready), 320'(1));
    chk("idle iready valid", 320'(o_valid), 320'(0));

    // n = 0 pass-through.
    s[0] = 64'd1; s[1] = 64'd2; s[2] = 64'd3; s[3] = 64'd4; s[4] = 64'd5;
    start(s, 4'd0);
    chk("n0 valid", 320'(o_valid), 320'(1));
    chk("n0 busy",  320'(o_busy),  320'(0));
    chk("n0 ready", 320'(o_ready), 320'(0));
    chk("n0 state", o_state, s);
    accept("n0");

    // n = 1 on zero state, hand-derived: post-S-box x0=x1=x3=0x4B, x2=~0x4B, x4=0.
    a = 64'h4B;
    b = ~a;
    exp[0] = a ^ ror(a, 19) ^ ror(a, 28);
    exp[1] = a ^ ror(a, 61) ^ ror(a, 39);
    exp[2] = b ^ ror(b, 1)  ^ ror(b, 6);
    exp[3] = a ^ ror(a, 10) ^ ror(a, 17);
    exp[4] = 64'd0;
    start('0, 4'd1);
    wait_valid(1, lat);
    chk("n1 latency", 320'(lat), 320'(exp_lat(1)));
    chk("n1 state", o_state, exp);
    chk("n1 model", o_state, m_perm('0, 1));
    accept("n1");

    // n = 12 on the Ascon-128 init state, with a stray request mid-run and back-pressure.
    init = '0;
    init[0] = 64'h80400c0600000000;
    exp = m_perm(init, 12);
    start(init, 4'd12);
    tick();
    tick();
    chk("run busy",  320'(o_busy),  320'(1));
    chk("run ready", 320'(o_ready), 320'(0));
    other = {5{64'hDEADBEEFCAFEF00D}};
    i_state  = other;
    i_rounds = 4'd1;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    wait_valid(4, lat);
    chk("n12 latency", 320'(lat), 320'(exp_lat(12)));
    chk("n12 state", o_state, exp);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp valid", 320'(o_valid), 320'(1));
      chk("bp state", o_state, exp);
    end
    accept("n12");

    // Clamp and intermediate round counts.
    run_chk("n15", init, 4'd15);
    chk("n15 vs n12", m_perm(init, 15), exp);
    s[0] = {$urandom, $urandom}; s[1] = {$urandom, $urandom}; s[2] = {$urandom, $urandom};
    s[3] = {$urandom, $urandom}; s[4] = {$urandom, $urandom};
    run_chk("n6", s, 4'd6);
    run_chk("n8", s, 4'd8);

    // Reset mid-RUN discards the job at once; a fresh start then completes.
    start(init, 4'd12);
    repeat (5) tick();
    #1 reset = 1'b1;
    #1;
    chk("mid rst valid", 320'(o_valid), 320'(0));
    chk("mid rst ready", 320'(o_ready), 320'(1));
    chk("mid rst busy",  320'(o_busy),  320'(0));
    chk("mid rst state", o_state, '0);
    #2 reset = 1'b0;
    tick();
    run_chk("post rst", init, 4'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/perm_sequencer.md
Name: perm_sequencer

Overview:
- Iterative Ascon permutation engine that runs p^n for n = 0..12 rounds, one round per clock.
- Owns the 320-bit state register, the round counter and the FSM; time-shares one combinational substitution layer (64 S-box columns) and one linear-diffusion stage across all rounds.
- Sits between the mode controllers (init/absorb/squeeze/finalize) and the round datapath.
- Uses valid/ready handshakes on both input and output.

Parameters:
- MAX_ROUNDS, 12, largest round count accepted; i_rounds above this is clamped to it.
- NUM_SBOXES, 64, columns passed to the substitution layer; fixed to the word width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  start request
- o_ready  out  1  engine idle, request accepted when i_valid & o_ready
- i_rounds  in  4  round count n; 0 is a legal pass-through
- i_state  in  t_state_array (5x64)  input state x0..x4, element [k] = xk
- o_valid  out  1  result available
- i_ready  in  1  consumer accepts result
- o_state  out  t_state_array  state register contents
- o_busy  out  1  high in RUN state

Behaviour:
- Reset (async, immediate):
  - FSM = IDLE, state register = 0, round index = 0.
  - o_ready = 1, o_valid = 0, o_busy = 0, o_state = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready = 1.
  - On handshake at edge E0: load i_state.
  - Set round index r = MAX_ROUNDS - n, where n = min(i_rounds, MAX_ROUNDS).
  - If n = 0, go to DONE. Otherwise go to RUN.
- RUN (o_ready = 0, o_busy = 1): each edge replaces the state with round(state, r) and increments r.
  - round(): x2 ^= {56'h0, c_r}, where c_r = {(4'hF - r[3:0]), r[3:0]}. Gives 0xF0 for r=0 and 0x4B for r=11.
  - Then the substitution layer: column i = {x0[i], x1[i], x2[i], x3[i], x4[i]}, x0 as MSB.
  - Then the linear layer, with rotr = rotate right:
    - x0 ^= rotr19 ^ rotr28
    - x1 ^= rotr61 ^ rotr39
    - x2 ^= rotr1 ^ rotr6
    - x3 ^= rotr10 ^ rotr17
    - x4 ^= rotr7 ^ rotr41
  - When the round just applied has r = MAX_ROUNDS-1, go to DONE.
- DONE:
  - o_valid = 1 and o_state is held stable until i_ready.
  - On i_valid & ... no: on o_valid & i_ready, go to IDLE.
  - o_ready stays 0 in DONE; there is no back-to-back start in the same cycle.
- Latency: handshake at E0, rounds at E1..En, o_valid high after En.
  - n rounds take n+1 edges from request to valid.
  - n = 0 gives o_valid after E0 with o_state = i_state.
- i_valid during RUN/DONE: ignored, and i_state is not sampled.
- i_rounds is sampled only at the handshake; later changes have no effect.
- i_ready while o_valid = 0 is ignored.
- Reset asserted mid-RUN or mid-DONE: all state returns to reset values immediately and the in-flight result is discarded.
- o_state always reflects the register, including intermediate round values during RUN. Consumers use it only when o_valid = 1.

Optional Feature:
- Macro: PERM_SPLIT_ROUND_EN.
- Defined:
  - A 320-bit pipeline register sits after the substitution layer (after constant addition + S-box); the linear layer is applied on the following edge.
  - Each round takes 2 edges; RUN alternates phase SUB/LIN using a 1-bit phase flag, reset to SUB.
  - n rounds take 2n+1 edges from request to valid.
  - n = 0 behaviour is unchanged.
  - Reset mid-phase clears the flag.
- Undefined: single-cycle round as above; no phase flag or extra register is synthesized.

Decomposition:
- Package ascon_pkg:
  - existing t_state_array;
  - add MAX_ROUNDS_C = 12;
  - add a t_perm_fsm enum {IDLE, RUN, DONE};
  - add a function returning c_r from a 4-bit round index.
- Sub-modules: reuse the existing substitution layer unchanged. One new sub-module, lin_layer (purely combinational, t_state_array in/out, the five rotate-XOR equations).
- The sequencer holds only the FSM, counter, constant add, muxing and registers.

Test Plan:
- Reset mid-RUN: start with n=12, assert reset after E5 -> o_valid=0, o_ready=1, o_state=0 immediately; a new start afterwards completes normally.
- n=0, i_state x0..x4 = 1,2,3,4,5 -> o_valid after one edge, o_state equals the input.
- n=1, all-zero state, MAX_ROUNDS=12 -> constant 0x4B. Post-S-box: x0=x1=x3=0x4B, x2=~0x4B (0xFFFFFFFFFFFFFFB4), x4=0. Final: x0 = 0x4B ^ rotr(0x4B,19) ^ rotr(0x4B,28), likewise per the lin_layer equations; o_valid after 2 edges.
- n=12 on the Ascon-128 init state (IV 0x80400c0600000000, key/nonce 0) -> o_state matches the golden software model bit-exact after 13 edges (25 with PERM_SPLIT_ROUND_EN).
- n=15 -> clamped to 12, same result and latency as n=12; n=6 and n=8 match the model.
- Back-pressure: hold i_ready=0 for 10 cycles in DONE -> o_state stable and o_valid held. Pulse i_valid during RUN with a different state -> ignored, result unaffected.
